// File: rtl/de2_led_pkg.sv
// rtl/de2_led_pkg.sv - shared encodings and reset values for the LED effect engine
package de2_led_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;
    localparam logic [1:0] MODE_SCAN  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [15:0] PERIOD_RST = 16'd1;
    localparam logic [7:0]  DUTY_RST   = 8'h80;

endpackage

// File: rtl/de2_led_tick_gen.sv
// rtl/de2_led_tick_gen.sv - prescaler producing a one-cycle timebase tick every PRESCALE clocks
module de2_led_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/de2_led_effect_engine.sv
// rtl/de2_led_effect_engine.sv - LEDG driver applying pass/blink/PWM/scan effects to the PIO pattern
module de2_led_effect_engine
    import de2_led_pkg::*;
#(
    parameter int N_LEDS   = 9,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_in,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [N_LEDS-1:0] led_out
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    logic              tick;
    logic              wr, restart, step;
    logic [15:0]       period_eff;
    logic [N_LEDS-1:0] scan_mask;
    logic              unused_wdata;

    logic [2:0]        ctrl_q, ctrl_d;
    logic [15:0]       period_q, period_d;
    logic [7:0]        duty_q, duty_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic              phase_q, phase_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_up_q, dir_up_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0] led_out_q, led_out_d;

    de2_led_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        wr         = chipselect && !write_n;
        restart    = wr && (address != ADDR_DUTY);
        period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
        step       = tick && (step_cnt_q == period_eff - 16'd1);
        scan_mask  = N_LEDS'(1) << pos_q;

        ctrl_d     = ctrl_q;
        period_d   = period_q;
        duty_d     = duty_q;
        step_cnt_d = step_cnt_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        dir_up_d   = dir_up_q;
        pwm_cnt_d  = pwm_cnt_q + 8'd1;

        if (wr) begin
            case (address)
                ADDR_CTRL:   ctrl_d   = writedata[2:0];
                ADDR_PERIOD: period_d = writedata[15:0];
                ADDR_DUTY:   duty_d   = writedata[7:0];
                default:     ;
            endcase
        end

        if (tick) begin
            step_cnt_d = step ? 16'd0 : step_cnt_q + 16'd1;
        end

        // Bounce off the ends: the end LED is lit for one step, never two.
        if (step) begin
            phase_d = ~phase_q;
            if (dir_up_q) begin
                if (pos_q == POS_MAX) begin
                    dir_up_d = 1'b0;
                    pos_d    = pos_q - 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    dir_up_d = 1'b1;
                    pos_d    = POS_W'(1);
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
        end

        // Restart overrides any step landing on the same edge.
        if (restart) begin
            step_cnt_d = 16'd0;
            phase_d    = 1'b0;
            pos_d      = '0;
            dir_up_d   = 1'b1;
            pwm_cnt_d  = 8'd0;
        end

        led_out_d = led_in;
        if (ctrl_q[2]) begin
            case (ctrl_q[1:0])
                MODE_BLINK: led_out_d = phase_q ? led_in : '0;
                MODE_PWM:   led_out_d = (pwm_cnt_q < duty_q) ? led_in : '0;
                MODE_SCAN:  led_out_d = led_in & scan_mask;
                default:    led_out_d = led_in;
            endcase
        end

        readdata = 32'd0;
        case (address)
            ADDR_CTRL:   readdata[2:0]  = ctrl_q;
            ADDR_PERIOD: readdata[15:0] = period_q;
            ADDR_DUTY:   readdata[7:0]  = duty_q;
            default: begin
                readdata[N_LEDS-1:0] = led_out_q;
                readdata[16]         = phase_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= 3'd0;
            period_q   <= PERIOD_RST;
            duty_q     <= DUTY_RST;
            step_cnt_q <= 16'd0;
            phase_q    <= 1'b0;
            pos_q      <= '0;
            dir_up_q   <= 1'b1;
            pwm_cnt_q  <= 8'd0;
            led_out_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            step_cnt_q <= step_cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            dir_up_q   <= dir_up_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_out_q  <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: doc/de2_led_effect_engine.md
# de2_led_effect_engine

Downstream consumer of the 9-bit green-LED PIO output port. Takes the CPU-written LED pattern and drives the board LEDG pins either unchanged or through a timed effect: blink, PWM dimming, or a bouncing scan. Software configures the effect through its own small Avalon-MM slave (zero wait-state, same register style as the PIO). All effect timing is derived from `clk` by an internal prescaler.

## Interface
- `N_LEDS`, 9: LED count; must equal the PIO width.
- `PRESCALE`, 50000: `clk` cycles per timebase tick (1 kHz at 50 MHz); must be ≥ 2.
- `clk` input 1: system clock.
- `reset_n` input 1: reset; asynchronous, active-low.
- `led_in` input N_LEDS: pattern from the PIO `out_port`.
- `address` input 2: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: combinational read data; unused bits are 0.
- `led_out` output N_LEDS: registered LED pin drive.

## Operation
Register map (a write happens when `chipselect && !write_n`):
- 0 CTRL: [1:0] mode (0 PASS, 1 BLINK, 2 PWM, 3 SCAN); [2] enable. Reset value 0.
- 1 PERIOD: [15:0] ticks per effect step. Reset value 1. A stored value of 0 behaves as 1.
- 2 DUTY: [7:0] PWM duty. Reset value 0x80.
- 3 STATUS: reads {15'b0, phase, 7'b0, led_out}. A write to STATUS restarts the effect; the data is ignored.

Reads return the register contents, zero-extended. Unimplemented bits read 0.

Timebase:
- A prescaler counts 0..PRESCALE-1 and emits a 1-cycle `tick` at the terminal count.
- A 16-bit step counter advances on each `tick`. When the count reaches PERIOD-1 it emits `step` and returns to 0.

Effect state: `phase` (1 bit), `pos` (0..N_LEDS-1), `dir` (up/down), and an 8-bit `pwm_cnt` that free-runs every `clk` and wraps at 255.

Next value of `led_out`:
- enable=0 or mode PASS: `led_in`.
- BLINK: `phase ? led_in : 0`. `phase` toggles on each `step`.
- PWM: `(pwm_cnt < DUTY) ? led_in : 0`.
  - DUTY=0 gives always off.
  - DUTY=255 gives 255/256 on.
- SCAN: `led_in & (1 << pos)`. On each `step`, `pos` moves one place in direction `dir`.
  - At `pos`=N_LEDS-1 moving up, `dir` flips to down and `pos` becomes N_LEDS-2.
  - At `pos`=0 moving down, `dir` flips to up and `pos` becomes 1.

Restart:
- Triggers: a write to CTRL, PERIOD or STATUS.
- Effect: step counter, `phase`, `pos` and `pwm_cnt` are cleared to 0, and `dir` is set to up.
- The prescaler is not reset.

## Timing
- Reset (async assert): `led_out`=0 and all registers take their reset values. After release, PASS mode is active from the first edge.
- `led_out` latency: 1 cycle from a `led_in` change, from a register write, or from a `step`.
- Writes take effect on the clock edge where they are sampled. Reads are valid in the same cycle (no wait states).
- Restart write in the same cycle as a `step`: the restart wins and no advance occurs.
- PERIOD written mid-count: the counter restarts, so no partial step is applied with the old value.
- Step interval is PERIOD×PRESCALE cycles. The first `step` after a restart comes after PERIOD ticks, give or take the prescaler phase (up to PRESCALE-1 extra cycles).
- Reset asserted mid-effect: all state clears immediately. No residual blink or scan state survives.

## Structure
- Package `de2_led_pkg` holds:
  - mode encodings `MODE_PASS`, `MODE_BLINK`, `MODE_PWM`, `MODE_SCAN`;
  - register addresses `ADDR_CTRL`, `ADDR_PERIOD`, `ADDR_DUTY`, `ADDR_STATUS`;
  - reset constants for PERIOD and DUTY.
- Sub-module `de2_led_tick_gen` (parameter PRESCALE; ports `clk`, `reset_n`, `tick`) is the only sub-module. Step counter, effect state, register file and output mux stay in the top level.

## Test plan
- Reset, then `led_in`=0x1A5 with CTRL untouched → `led_out`=0x1A5 one cycle later; reading CTRL returns 0.
- PRESCALE=4, PERIOD=2, CTRL=0x5 (BLINK, enabled), `led_in`=0x1FF → `led_out` 0 for 8 cycles, then 0x1FF for 8 cycles, repeating; STATUS[16] tracks `phase`.
- PWM, DUTY=64, `led_in`=0x001 → `led_out`[0] high for exactly 64 of every 256 cycles. DUTY=0 → never high. DUTY=255 → high for 255 of 256.
- SCAN, PRESCALE=4, PERIOD=1, `led_in`=0x1FF → `led_out` steps 0x001, 0x002 … 0x100, 0x080 … 0x001, changing every 4 cycles. With `led_in`=0x0F0 the low positions read 0.
- Write STATUS in the same cycle as a `step` → no advance; `phase` and `pos` are 0. Write PERIOD=0 → behaves as PERIOD=1.
- Assert `reset_n` mid-SCAN → `led_out`=0 asynchronously. After release, PASS mode with DUTY reading 0x80 and PERIOD reading 1.
